// File: rtl/rom_access_arbiter.sv
// Two-port arbiter sharing one synchronous chip-select-gated ROM between the CPU bus
// (port 0, fixed priority) and a secondary reader (port 1) with a starvation guard.
module rom_access_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_lock,
    output logic                  p0_ack,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_ack,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = 4'hF;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);

    logic [1:0]       last_grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             grant0;
    logic             grant1;

    // Grant decision: port 0 wins contention unless port 1 has waited long enough
    // and port 0 is not holding the lock.
    always_comb begin
        starve_hit = (starve_cnt >= LIMIT);
        grant0     = p0_req && !(p1_req && starve_hit && !p0_lock);
        grant1     = p1_req && !grant0;
        p0_ack     = grant0;
        p1_ack     = grant1;
        rom_cs     = grant0 || grant1;
        rom_addr   = '0;
        if (grant0) begin
            rom_addr = p0_addr;
        end else if (grant1) begin
            rom_addr = p1_addr;
        end
    end

    // Grant history drives rvalid; the wait counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 2'b00;
            starve_cnt <= '0;
        end else begin
            last_grant <= {grant1, grant0};
            if (grant1 || !p1_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign p0_rvalid = last_grant[0];
    assign p1_rvalid = last_grant[1];
    assign p0_rdata  = rom_data;
    assign p1_rdata  = rom_data;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed table-driven bench for rom_access_arbiter with a behavioural synchronous ROM.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_lock, p1_req;
    logic [15:0] p0_addr, p1_addr;
    logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_lock(p0_lock),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // ROM model: one-cycle latency, output held while deselected.
    always @(posedge clk) begin
        if (rom_cs) rom_data <= rom_fn(rom_addr);
    end

    typedef struct {
        logic        p0_req;
        logic [15:0] p0_addr;
        logic        p0_lock;
        logic        p1_req;
        logic [15:0] p1_addr;
        logic        e_ack0;
        logic        e_ack1;
        logic [15:0] e_addr;
        logic        e_rv0;
        logic        e_rv1;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[$];

    // Appends one cycle; rvalid/rdata expectations follow from the previous row's grant.
    function automatic void add(input logic p0r, input logic [15:0] a0, input logic lk,
                                input logic p1r, input logic [15:0] a1,
                                input logic ea0, input logic ea1);
        vec_t v;
        v.p0_req = p0r; v.p0_addr = a0; v.p0_lock = lk;
        v.p1_req = p1r; v.p1_addr = a1;
        v.e_ack0 = ea0; v.e_ack1 = ea1;
        v.e_addr = ea0 ? a0 : (ea1 ? a1 : 16'h0000);
        if (vecs.size() == 0) begin
            v.e_rv0 = 1'b0; v.e_rv1 = 1'b0; v.e_data = 8'h00;
        end else begin
            v.e_rv0  = vecs[vecs.size()-1].e_ack0;
            v.e_rv1  = vecs[vecs.size()-1].e_ack1;
            v.e_data = rom_fn(vecs[vecs.size()-1].e_addr);
        end
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic p0r, input logic [15:0] a0,
                         input logic lk, input logic p1r, input logic [15:0] a1);
        @(negedge clk);
        reset_n = rst; p0_req = p0r; p0_addr = a0; p0_lock = lk;
        p1_req = p1r; p1_addr = a1;
        #2;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(1'b1, v.p0_req, v.p0_addr, v.p0_lock, v.p1_req, v.p1_addr);
        chk($sformatf("v%0d.p0_ack", idx), 32'(p0_ack), 32'(v.e_ack0));
        chk($sformatf("v%0d.p1_ack", idx), 32'(p1_ack), 32'(v.e_ack1));
        chk($sformatf("v%0d.rom_cs", idx), 32'(rom_cs), 32'(v.e_ack0 | v.e_ack1));
        chk($sformatf("v%0d.rom_addr", idx), 32'(rom_addr), 32'(v.e_addr));
        chk($sformatf("v%0d.p0_rvalid", idx), 32'(p0_rvalid), 32'(v.e_rv0));
        chk($sformatf("v%0d.p1_rvalid", idx), 32'(p1_rvalid), 32'(v.e_rv1));
        if (v.e_rv0) chk($sformatf("v%0d.p0_rdata", idx), 32'(p0_rdata), 32'(v.e_data));
        if (v.e_rv1) chk($sformatf("v%0d.p1_rdata", idx), 32'(p1_rdata), 32'(v.e_data));
    endtask

    initial begin
        reset_n = 1'b0; p0_req = 1'b0; p0_addr = '0; p0_lock = 1'b0;
        p1_req = 1'b0; p1_addr = '0;

        // Single port 0, then back-to-back port 1.
        add(1'b1, 16'h00F3, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Contention without lock: p0 x4, p1, p0 x4, p1.
        for (int i = 0; i < 10; i++)
            add(1'b1, 16'h0100, 1'b0, 1'b1, 16'h0200, (i % 5) != 4, (i % 5) == 4);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Lock for 20 cycles, then drop: p1 wins the same cycle.
        for (int i = 0; i < 20; i++)
            add(1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b0);
        add(1'b1, 16'h0100, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Exactly 16 locked waits: a wrapping counter would read 0 here.
        for (int i = 0; i < 16; i++)
            add(1'b1, 16'h0101, 1'b1, 1'b1, 16'h0201, 1'b1, 1'b0);
        add(1'b1, 16'h0101, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Lock rising while starve_hit returns priority to p0; falling hands it to p1.
        for (int i = 0; i < 4; i++)
            add(1'b1, 16'h0102, 1'b0, 1'b1, 16'h0202, 1'b1, 1'b0);
        add(1'b1, 16'h0102, 1'b1, 1'b1, 16'h0202, 1'b1, 1'b0);
        add(1'b1, 16'h0102, 1'b0, 1'b1, 16'h0202, 1'b0, 1'b1);
        add(1'b1, 16'h0103, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset held for 3 cycles with both requests low.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("rst%0d.p0_rvalid", i), 32'(p0_rvalid), 32'd0);
            chk($sformatf("rst%0d.p1_rvalid", i), 32'(p1_rvalid), 32'd0);
            chk($sformatf("rst%0d.rom_cs", i), 32'(rom_cs), 32'd0);
        end

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-stream: p1 ack, then reset with the rvalid of that ack visible.
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030);
        chk("mid.p1_ack", 32'(p1_ack), 32'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("mid.p1_rvalid_pre", 32'(p1_rvalid), 32'd1);
        chk("mid.p1_rdata_pre", 32'(p1_rdata), 32'(rom_fn(16'h0030)));
        // Access granted during reset is acked but must produce no rvalid.
        drive(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
        chk("mid.p1_rvalid_rst", 32'(p1_rvalid), 32'd0);
        chk("mid.p0_ack_rst", 32'(p0_ack), 32'd1);
        chk("mid.rom_addr_rst", 32'(rom_addr), 32'h0040);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("mid.p0_rvalid_post", 32'(p0_rvalid), 32'd0);
        chk("mid.p1_rvalid_post", 32'(p1_rvalid), 32'd0);
        // Counter restarts from zero: p0 wins four contended cycles, then p1.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h0400);
            chk($sformatf("post%0d.p0_ack", i), 32'(p0_ack), 32'(i != 4));
            chk($sformatf("post%0d.p1_ack", i), 32'(p1_ack), 32'(i == 4));
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("post.p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("post.p1_rdata", 32'(p1_rdata), 32'(rom_fn(16'h0400)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
